// File: rtl/i2s_audio_rx.sv
// i2s_audio_rx: slave Philips-format I2S receiver.
// Synchronises BCK/LRCK/SDIN into the system clock and deserialises MSB-first words.
// Presents a stereo pair with a one-cycle strobe once a left slot and then a right slot have both completed.
module i2s_audio_rx #(
  parameter int DATA_W      = 16,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              i2s_bck,
  input  logic              i2s_lrck,
  input  logic              i2s_sdin,
  output logic [DATA_W-1:0] L_data,
  output logic [DATA_W-1:0] R_data,
  output logic              sample_valid,
  output logic              frame_err,
  output logic              locked
);

  localparam int CNT_W = $clog2(SLOT_W + 1);

  typedef enum logic [1:0] {S_UNSYNC, S_LEFT, S_RIGHT} state_t;

  logic [SYNC_STAGES-1:0] bck_sync_q, lrck_sync_q, sdin_sync_q;
  logic                   bck_d_q;
  logic                   bck_s, lrck_s, sdin_s, bck_rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      left_stage_q, left_stage_d;
  logic                   lrck_q, lrck_d;
  logic [DATA_W-1:0]      l_data_q, l_data_d;
  logic [DATA_W-1:0]      r_data_q, r_data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   locked_q, locked_d;
  logic [DATA_W-1:0]      word;

  assign bck_s    = bck_sync_q[SYNC_STAGES-1];
  assign lrck_s   = lrck_sync_q[SYNC_STAGES-1];
  assign sdin_s   = sdin_sync_q[SYNC_STAGES-1];
  assign bck_rise = bck_s & ~bck_d_q;

  // Synchronise the three async pins and keep one extra BCK stage for edge detection.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      bck_sync_q  <= '0;
      lrck_sync_q <= '0;
      sdin_sync_q <= '0;
      bck_d_q     <= 1'b0;
    end else begin
      bck_sync_q  <= {bck_sync_q[SYNC_STAGES-2:0], i2s_bck};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
      sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], i2s_sdin};
      bck_d_q     <= bck_s;
    end
  end

  // Per BCK rise: store the bit, count the slot, and on an LRCK change close the word and step the FSM.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    left_stage_d = left_stage_q;
    lrck_d       = lrck_q;
    l_data_d     = l_data_q;
    r_data_d     = r_data_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    word         = shreg_q;
    if (bck_rise) begin
      // Bits beyond DATA_W never match any position, so they are dropped.
      for (int i = 0; i < DATA_W; i++) begin
        if (32'(bit_cnt_q) == DATA_W - 1 - i) word[i] = sdin_s;
      end
      if (lrck_s != lrck_q) begin
        // The edge where LRCK flips still carries the LSB of the slot being closed.
        bit_cnt_d = '0;
        shreg_d   = '0;
        lrck_d    = lrck_s;
        case (state_q)
          S_UNSYNC: if (!lrck_s) state_d = S_LEFT;
          S_LEFT: begin
            if (lrck_s) begin
              left_stage_d = word;
              state_d      = S_RIGHT;
            end
          end
          S_RIGHT: begin
            if (!lrck_s) begin
              l_data_d = left_stage_q;
              r_data_d = word;
              valid_d  = 1'b1;
              state_d  = S_LEFT;
            end
          end
          default: state_d = S_UNSYNC;
        endcase
      end else begin
        shreg_d = word;
        // Saturating count; the single step onto SLOT_W flags an overlong slot.
        if (bit_cnt_q != CNT_W'(SLOT_W)) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(SLOT_W - 1)) err_d = 1'b1;
        end
      end
    end
    locked_d = (state_d != S_UNSYNC);
  end

  // Register FSM state, deserialiser state and all outputs.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q      <= S_UNSYNC;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      left_stage_q <= '0;
      lrck_q       <= 1'b0;
      l_data_q     <= '0;
      r_data_q     <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      left_stage_q <= left_stage_d;
      lrck_q       <= lrck_d;
      l_data_q     <= l_data_d;
      r_data_q     <= r_data_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
    end
  end

  assign L_data       = l_data_q;
  assign R_data       = r_data_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Bench for i2s_audio_rx: directed I2S frames, expected pairs queued at stimulus time, monitor checks each strobe.
`timescale 1ns/1ps
module tb_i2s_audio_rx;

  localparam int H = 163;  // BCK half period, ~3.07 MHz

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bck = 1'b0, lrck = 1'b1, sdin = 1'b0;
  logic [15:0] l_data, r_data;
  logic        sample_valid, frame_err, locked;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int valid_cnt = 0;
  logic [31:0] exp_q[$];

  i2s_audio_rx #(.DATA_W(16), .SLOT_W(32), .SYNC_STAGES(2)) dut (
    .clk_50MHz   (clk),
    .reset       (reset),
    .i2s_bck     (bck),
    .i2s_lrck    (lrck),
    .i2s_sdin    (sdin),
    .L_data      (l_data),
    .R_data      (r_data),
    .sample_valid(sample_valid),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  always #10 clk = ~clk;

  // Monitor: every strobe pops one expected pair; frame_err pulses are tallied.
  always @(negedge clk) begin
    logic [31:0] e;
    if (sample_valid) begin
      valid_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got L=%h R=%h required no strobe", l_data, r_data);
      end else begin
        e = exp_q.pop_front();
        if ({l_data, r_data} !== e) begin
          bad++;
          $display("FAIL pair got L=%h R=%h required L=%h R=%h", l_data, r_data, e[31:16], e[15:0]);
        end else begin
          $display("pair L=%h R=%h ok", l_data, r_data);
        end
      end
    end
    if (frame_err) begin
      err_cnt++;
      $display("frame_err pulse #%0d", err_cnt);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  // One BCK period: LRCK/SDIN change with the falling edge, DUT samples on the rise.
  task automatic send_bit(input logic lr, input logic d);
    bck = 1'b0; lrck = lr; sdin = d;
    #H;
    bck = 1'b1;
    #H;
  endtask

  // Bits hi..lo of data MSB-first; bit 0 goes out with the next slot's LRCK (1-bit I2S delay).
  task automatic send_range(input logic lr, input logic nlr, input logic [63:0] data,
                            input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit((i == 0) ? nlr : lr, data[i]);
  endtask

  int vc, ec;

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_L", 32'(l_data), 32'h0);
    chk("rst_R", 32'(r_data), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Start mid right slot with LRCK=1; the final bit flips LRCK to left and locks.
    send_range(1'b1, 1'b0, 64'h2AA, 9, 0);

    // 1) 32-bit slots
    exp_q.push_back({16'h1234, 16'hABCD});
    send_range(1'b0, 1'b1, 64'h1234_5678, 31, 0);
    send_range(1'b1, 1'b0, 64'hABCD_9876, 31, 0);
    #200;
    chk("t1_locked", 32'(locked), 32'h1);

    // 2) 16-bit slots, three frames
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back({16'h8001, 16'h7FFE});
      send_range(1'b0, 1'b1, 64'h8001, 15, 0);
      send_range(1'b1, 1'b0, 64'h7FFE, 15, 0);
    end
    #1000;
    chk("t2_no_err", 32'(err_cnt), 32'h0);

    // 3) 24-bit data in 32-bit slot truncated; 8-bit slot zero-padded
    exp_q.push_back({16'h1234, 16'hA500});
    send_range(1'b0, 1'b1, 64'h1234_5600, 31, 0);
    send_range(1'b1, 1'b0, 64'hA5, 7, 0);

    // 4) 40-bit left slot: one frame_err, top 16 bits still delivered
    exp_q.push_back({16'hBEEF, 16'h5555});
    send_range(1'b0, 1'b1, 64'hBE_EF00_0011, 39, 0);
    send_range(1'b1, 1'b0, 64'h5555_0000, 31, 0);
    #1000;
    chk("t4_one_err", 32'(err_cnt), 32'h1);

    // 5) reset in the middle of the right slot
    send_range(1'b0, 1'b1, 64'h1111_1111, 31, 0);
    send_range(1'b1, 1'b1, 64'h9999_9999, 31, 22);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_L", 32'(l_data), 32'h0);
    chk("t5_R", 32'(r_data), 32'h0);
    chk("t5_locked", 32'(locked), 32'h0);
    chk("t5_valid", 32'(sample_valid), 32'h0);
    reset = 1'b0;
    send_range(1'b1, 1'b0, 64'h9999_9999, 21, 0);
    exp_q.push_back({16'h2222, 16'h3333});
    send_range(1'b0, 1'b1, 64'h2222_0000, 31, 0);
    send_range(1'b1, 1'b0, 64'h3333_0000, 31, 0);
    #500;

    // 6) BCK stalled low mid left slot, then resumed
    exp_q.push_back({16'h4444, 16'h6666});
    send_range(1'b0, 1'b1, 64'h4444_5555, 31, 16);
    vc = valid_cnt;
    ec = err_cnt;
    bck = 1'b0;
    #200000;
    chk("t6_no_valid", 32'(valid_cnt), 32'(vc));
    chk("t6_no_err", 32'(err_cnt), 32'(ec));
    chk("t6_hold_L", 32'(l_data), 32'h2222);
    chk("t6_hold_R", 32'(r_data), 32'h3333);
    chk("t6_locked", 32'(locked), 32'h1);
    send_range(1'b0, 1'b1, 64'h4444_5555, 15, 0);
    send_range(1'b1, 1'b0, 64'h6666_7777, 31, 0);

    #2000;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    chk("valid_total", 32'(valid_cnt), 32'd8);
    chk("err_total", 32'(err_cnt), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
